sram_responder: RTL
===================

Name: sram_responder

Overview:
- Cache-side responder for the CPU's split instruction/data request interface. Serves ren/wen requests one at a time.
- Accepts requests against a single-port synchronous word memory with configurable wait states.
- Returns a one-cycle valid pulse with read data.
- Sits between the CPU request bridge and on-chip RAM; stands in for the cache in functional SoC builds.

Parameters:
- MEM_AW, 16, word-address width of memory port (byte address bits [MEM_AW+1:2] used).
- WAIT_CYCLES, 0, extra memory read/write latency cycles; legal range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- inst_addr  input  32  instruction byte address, held stable while inst_ren high.
- inst_ren  input  1  instruction read request, level, held until inst_valid.
- inst_valid  output  1  one-cycle response pulse for instruction read.
- inst_rd  output  32  instruction read data; valid with inst_valid, held afterwards.
- data_addr  input  32  data byte address.
- data_ren  input  1  data read request, level.
- data_wen  input  4  byte write enables; non-zero = write request, level.
- data_wd  input  32  write data.
- data_valid  output  1  one-cycle response pulse for a data read or write.
- data_rd  output  32  data read data; valid with data_valid on reads.
- mem_en  output  1  memory access strobe, registered.
- mem_we  output  4  memory byte write enables, registered.
- mem_addr  output  MEM_AW  memory word address, registered.
- mem_wdata  output  32  memory write data, registered.
- mem_rdata  input  32  memory read data, valid 1+WAIT_CYCLES cycles after the mem_en cycle.

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0; wait counter 0.
- Reset mid-access aborts the access: no valid pulse; a write not yet clocked at the ACCESS edge is not performed.
- States:
  - IDLE: sample requests every cycle.
    - Priority: data_ren > data_wen!=0 > inst_ren.
    - data_ren and data_wen both active: treated as a read; wen ignored.
    - On accept, capture type, addr[MEM_AW+1:2], wen, wd into request regs; go ACCESS. Otherwise stay.
  - ACCESS (1 cycle): mem_en=1, mem_addr/mem_we/mem_wdata from request regs; mem_we=0 for reads. Go WAIT, counter=0.
  - WAIT: mem_en=0, mem_we=0. Count to WAIT_CYCLES. At the closing edge of the cycle where counter==WAIT_CYCLES, register the response and go RESP:
    - Read: capture mem_rdata into inst_rd or data_rd.
    - Write: data_rd unchanged.
  - RESP (1 cycle): exactly one of inst_valid/data_valid high. Requests present this cycle are ignored. Go IDLE.
- Latency, with the request-accept cycle as cycle 0: ACCESS is cycle 1, WAIT is cycles 2..2+WAIT_CYCLES, valid is cycle 3+WAIT_CYCLES.
- Throughput: one transaction per 4+WAIT_CYCLES cycles.
- A pending inst request that loses arbitration to a data request stays pending. It is served from the next IDLE, after the data response.
- inst_rd/data_rd hold their last read value until the next read of that type.
- Valid pulses are never simultaneous and never longer than 1 cycle.
- Request dropped by the requester before valid: the transaction still completes and pulses valid (no cancel).
- Address bits [1:0] and bits above MEM_AW+1 are ignored; no alignment check.

Decomposition:
- Shared header (defines.v): state encodings IDLE/ACCESS/WAIT/RESP; request-type constants REQ_INST, REQ_DREAD, REQ_DWRITE.
- No sub-module: arbiter, FSM, counter and response regs in one module of roughly 150–200 lines.
- Memory model lives in the testbench only.

Test Plan:
- WAIT_CYCLES=0, inst_ren=1 at addr 0x0000_0010 with mem word 4 = 0x2402_0001 -> inst_valid exactly at cycle 3, inst_rd=0x2402_0001, mem_addr=4, mem_we=0.
- WAIT_CYCLES=3, data_wen=4'b0011, data_addr=0x0000_0008, data_wd=0xAABB_CCDD -> mem_we=0011, mem_addr=2, mem_wdata=0xAABB_CCDD in cycle 1. data_valid at cycle 6, data_rd unchanged. Later read of addr 8 returns 0x????_CCDD lower half written.
- inst_ren and data_ren asserted together, both held -> data served first (data_valid cycle 3), inst served next (inst_valid cycle 7). No overlap of valid pulses.
- data_ren=1 and data_wen=4'b1111 together -> read performed, mem_we stays 0, memory contents unchanged.
- resetn pulled low during WAIT of a read -> all outputs 0 immediately (async). No valid after release; the next request is served normally from IDLE.
- Back-to-back inst reads at 0x0,0x4,0x8 with requester reissuing the cycle after each valid -> valids spaced exactly 4 cycles apart (WAIT_CYCLES=0), correct data each.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared types for the SRAM responder: FSM states, request kinds and arbitration.
package sram_responder_pkg;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REQ_INST   = 2'd0,
      REQ_DREAD  = 2'd1,
      REQ_DWRITE = 2'd2
   } req_t;

   // Data read wins over data write (a combined ren+wen is a read), data beats instruction.
   function automatic req_t pick_req(input logic dren, input logic [3:0] dwen);
      if (dren)
         return REQ_DREAD;
      else if (|dwen)
         return REQ_DWRITE;
      else
         return REQ_INST;
   endfunction

endpackage

// File: rtl/sram_responder.sv
// Single-outstanding responder for the split instruction/data request ports,
// driving a single-port synchronous word memory with configurable wait states.
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int MEM_AW      = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       inst_addr,
   input  logic              inst_ren,
   output logic              inst_valid,
   output logic [31:0]       inst_rd,
   input  logic [31:0]       data_addr,
   input  logic              data_ren,
   input  logic [3:0]        data_wen,
   input  logic [31:0]       data_wd,
   output logic              data_valid,
   output logic [31:0]       data_rd,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t              r_state;
   req_t                r_req;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic                r_mem_en;
   logic [3:0]          r_mem_we;
   logic [MEM_AW-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_inst_valid;
   logic [31:0]         r_inst_rd;
   logic                r_data_valid;
   logic [31:0]         r_data_rd;

   logic                w_any_req;
   req_t                w_req_sel;
   logic [MEM_AW-1:0]   w_addr;
   logic                w_cnt_done;
   logic                w_unused_bits;

   assign w_any_req  = data_ren | (|data_wen) | inst_ren;
   assign w_req_sel  = pick_req(data_ren, data_wen);
   assign w_addr     = (w_req_sel == REQ_INST) ? inst_addr[MEM_AW+1:2] : data_addr[MEM_AW+1:2];
   assign w_cnt_done = (r_wait_cnt == CNT_W'(WAIT_CYCLES));

   assign w_unused_bits = ^{inst_addr[1:0], inst_addr[31:MEM_AW+2],
                            data_addr[1:0], data_addr[31:MEM_AW+2]};

   // The mem_* registers double as the captured request: they are loaded on accept
   // so the memory sees them during the ACCESS cycle without an extra stage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_req        <= REQ_INST;
         r_wait_cnt   <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_inst_valid <= 1'b0;
         r_inst_rd    <= '0;
         r_data_valid <= 1'b0;
         r_data_rd    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_req       <= w_req_sel;
                  r_mem_en    <= 1'b1;
                  r_mem_addr  <= w_addr;
                  r_mem_we    <= (w_req_sel == REQ_DWRITE) ? data_wen : 4'b0000;
                  r_mem_wdata <= data_wd;
                  r_state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               r_mem_en   <= 1'b0;
               r_mem_we   <= '0;
               r_wait_cnt <= '0;
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_cnt_done) begin
                  case (r_req)
                     REQ_INST: begin
                        r_inst_rd    <= mem_rdata;
                        r_inst_valid <= 1'b1;
                     end
                     REQ_DREAD: begin
                        r_data_rd    <= mem_rdata;
                        r_data_valid <= 1'b1;
                     end
                     default: begin
                        r_data_valid <= 1'b1;
                     end
                  endcase
                  r_state <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_inst_valid <= 1'b0;
               r_data_valid <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign inst_valid = r_inst_valid;
   assign inst_rd    = r_inst_rd;
   assign data_valid = r_data_valid;
   assign data_rd    = r_data_rd;

endmodule
